vga_plot_arbiter: RTL and testbench

// - Shares the single VGA adapter pixel port between N_REQ drawing engines (circle, reuleaux, fill).
// - Grants one engine at a time, round-robin, and drives that engine's start.
// - Forwards the granted engine's pixel stream to the adapter through one register stage, clipping off-screen pixels.
// - Sits between the engines and vga_adapter, replacing ad-hoc per-shape output muxing.

---
 rtl/vga_pkg.sv | 17 +
 rtl/rr_picker.sv | 35 +++
 rtl/vga_plot_arbiter.sv | 153 +++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, pixel field widths and arbiter state type
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RUN,
        ARB_RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first set request at or after ptr, wrapping
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [PTR_W-1:0] win_idx
);

    logic [PTR_W:0]   slot;
    logic [PTR_W-1:0] idx;

    // Scan from the farthest offset back to ptr so the nearest requester overwrites the rest.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        slot    = '0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            slot = {1'b0, ptr} + (PTR_W+1)'(k);
            if (slot >= (PTR_W+1)'(N_REQ)) begin
                slot = slot - (PTR_W+1)'(N_REQ);
            end
            idx = slot[PTR_W-1:0];
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin owner of the VGA pixel port; forwards and clips the granted engine's pixels
module vga_plot_arbiter #(
    parameter int N_REQ    = 3,
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H,
    parameter int TIMEOUT  = 20000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req,
    output logic [N_REQ-1:0]                gnt,
    output logic [N_REQ-1:0]                job_done,
    output logic                            job_abort,
    output logic [N_REQ-1:0]                eng_start,
    input  logic [N_REQ-1:0]                eng_done,
    input  logic [N_REQ*vga_pkg::X_W-1:0]   eng_x,
    input  logic [N_REQ*vga_pkg::Y_W-1:0]   eng_y,
    input  logic [N_REQ*vga_pkg::C_W-1:0]   eng_colour,
    input  logic [N_REQ-1:0]                eng_plot,
    output logic [vga_pkg::X_W-1:0]         vga_x,
    output logic [vga_pkg::Y_W-1:0]         vga_y,
    output logic [vga_pkg::C_W-1:0]         vga_colour,
    output logic                            vga_plot,
    output logic [15:0]                     plot_count,
    output logic                            busy
);

    import vga_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TC_W  = $clog2(TIMEOUT + 1);
    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

    arb_state_t       state, state_nx;
    logic [PTR_W-1:0] ptr, w_idx, pick_idx;
    logic [N_REQ-1:0] pick;
    logic [TC_W-1:0]  tcount;
    logic             abort_flag;

    logic [X_W-1:0] x_arr [N_REQ];
    logic [Y_W-1:0] y_arr [N_REQ];
    logic [C_W-1:0] c_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign x_arr[i] = eng_x[X_W*i +: X_W];
        assign y_arr[i] = eng_y[Y_W*i +: Y_W];
        assign c_arr[i] = eng_colour[C_W*i +: C_W];
    end

    rr_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_picker (
        .req     (req),
        .ptr     (ptr),
        .winner  (pick),
        .win_idx (pick_idx)
    );

    logic [X_W-1:0] sel_x;
    logic [Y_W-1:0] sel_y;
    logic [C_W-1:0] sel_c;
    logic           sel_plot, sel_done, timed_out, finish, fwd;

    assign sel_x     = x_arr[w_idx];
    assign sel_y     = y_arr[w_idx];
    assign sel_c     = c_arr[w_idx];
    assign sel_plot  = eng_plot[w_idx];
    assign sel_done  = eng_done[w_idx];
    assign timed_out = (tcount == TC_W'(TIMEOUT));
    assign finish    = sel_done || timed_out;
    assign fwd       = sel_plot && ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
    assign busy      = (state != ARB_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ARB_IDLE:    if (|req)     state_nx = ARB_GRANT;
            ARB_GRANT:                 state_nx = ARB_RUN;
            ARB_RUN:     if (finish)   state_nx = ARB_RELEASE;
            ARB_RELEASE: if (!sel_done) state_nx = ARB_IDLE;
            default:                   state_nx = ARB_IDLE;
        endcase
    end

    // Done wins over a same-cycle timeout, so a job that finishes on the last cycle is not reported aborted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt        <= '0;
            job_done   <= '0;
            job_abort  <= 1'b0;
            eng_start  <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            plot_count <= '0;
            ptr        <= '0;
            w_idx      <= '0;
            tcount     <= '0;
            abort_flag <= 1'b0;
        end else begin
            job_done  <= '0;
            job_abort <= 1'b0;
            vga_plot  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        gnt        <= pick;
                        w_idx      <= pick_idx;
                        plot_count <= '0;
                    end
                end
                ARB_GRANT: begin
                    eng_start  <= gnt;
                    tcount     <= '0;
                    abort_flag <= 1'b0;
                end
                ARB_RUN: begin
                    vga_x      <= sel_x;
                    vga_y      <= sel_y;
                    vga_colour <= sel_c;
                    if (finish) begin
                        eng_start  <= '0;
                        abort_flag <= !sel_done;
                    end else begin
                        vga_plot <= fwd;
                        tcount   <= tcount + 1'b1;
                        if (fwd && plot_count != 16'hFFFF) begin
                            plot_count <= plot_count + 16'd1;
                        end
                    end
                end
                ARB_RELEASE: begin
                    if (!sel_done) begin
                        job_done  <= gnt;
                        job_abort <= abort_flag;
                        ptr       <= (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
                        gnt       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - randomized self-checking bench with behavioural engines and round-robin model
module tb_vga_plot_arbiter;

    localparam int N  = 3;
    localparam int TO = 50;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  gnt, job_done, eng_start, eng_done, eng_plot;
    logic        job_abort, vga_plot, busy;
    logic [23:0] eng_x;
    logic [20:0] eng_y;
    logic [8:0]  eng_colour;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic [15:0] plot_count;

    pix_t script [N][$];
    int   pos    [N];
    bit   stuck  [N];
    bit   noise  [N];
    int   checks = 0;
    int   errors = 0;
    int   model_ptr = 0;

    vga_plot_arbiter #(.N_REQ(N), .SCREEN_W(160), .SCREEN_H(120), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .job_done(job_done), .job_abort(job_abort),
        .eng_start(eng_start), .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y),
        .eng_colour(eng_colour), .eng_plot(eng_plot), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .plot_count(plot_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Engine i replays its script one pixel per cycle while started, then holds done until start drops.
    initial begin
        eng_x = '0; eng_y = '0; eng_colour = '0; eng_plot = '0; eng_done = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (eng_start[i]) begin
                    if (pos[i] < script[i].size()) begin
                        eng_x[8*i +: 8]      = script[i][pos[i]].x;
                        eng_y[7*i +: 7]      = script[i][pos[i]].y;
                        eng_colour[3*i +: 3] = script[i][pos[i]].c;
                        eng_plot[i]          = script[i][pos[i]].p;
                        eng_done[i]          = 1'b0;
                        pos[i]++;
                    end else begin
                        eng_plot[i] = 1'b0;
                        eng_done[i] = !stuck[i];
                    end
                end else begin
                    pos[i]      = 0;
                    eng_plot[i] = 1'b0;
                    eng_done[i] = 1'b0;
                    if (noise[i]) begin
                        eng_x[8*i +: 8]      = 8'($urandom);
                        eng_y[7*i +: 7]      = 7'($urandom);
                        eng_colour[3*i +: 3] = 3'($urandom);
                        eng_plot[i]          = 1'($urandom);
                        eng_done[i]          = 1'($urandom);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic pix_t mk(input int x, input int y, input int c, input bit p);
        pix_t q;
        q.x = 8'(x); q.y = 7'(y); q.c = 3'(c); q.p = p;
        return q;
    endfunction

    function automatic int rr_pick(input logic [2:0] pend, input int p);
        for (int k = 0; k < N; k++) begin
            if (pend[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic fill_random(input int i, input int len);
        script[i].delete();
        for (int m = 0; m < len; m++) begin
            script[i].push_back(mk($urandom_range(0, 200), $urandom_range(0, 127),
                                   $urandom_range(0, 7), $urandom_range(0, 3) != 0));
        end
    endtask

    task automatic run_jobs(input logic [2:0] mask, input int njobs, input bit hold);
        int order[$];
        logic [17:0] obs[$];
        logic [17:0] expq[$];
        logic [2:0] pend;
        int p, done_cnt, cyc, gaps, overlaps, start_cyc;
        pend = mask; p = model_ptr;
        for (int j = 0; j < njobs; j++) begin
            int w;
            w = rr_pick(pend, p);
            order.push_back(w);
            p = (w + 1) % N;
            if (!hold) pend[w] = 1'b0;
        end
        done_cnt = 0; cyc = 0; gaps = 0; overlaps = 0; start_cyc = 0;
        req = mask;
        while (done_cnt < njobs && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
            if ($countones(gnt) > 1) overlaps++;
            if (eng_start != 0) start_cyc++;
            if (vga_plot) obs.push_back({vga_x, vga_y, vga_colour});
            if (job_done != 0) begin
                int k;
                bit same;
                k = order[done_cnt];
                expq.delete();
                for (int m = 0; m < script[k].size(); m++) begin
                    if (script[k][m].p && script[k][m].x < 160 && script[k][m].y < 120)
                        expq.push_back({script[k][m].x, script[k][m].y, script[k][m].c});
                end
                checks++;
                if (job_done !== 3'(1 << k)) begin
                    errors++; $display("FAIL job_order: job_done=%b expected=%b", job_done, 3'(1 << k));
                end
                checks++;
                if (job_abort !== stuck[k]) begin
                    errors++; $display("FAIL job_abort: got=%b expected=%b (engine %0d)", job_abort, stuck[k], k);
                end
                checks++;
                if (plot_count !== 16'(expq.size())) begin
                    errors++; $display("FAIL plot_count: got=%0d expected=%0d (engine %0d)", plot_count, expq.size(), k);
                end
                same = (obs.size() == expq.size());
                for (int m = 0; m < obs.size(); m++) if (same && obs[m] !== expq[m]) same = 0;
                checks++;
                if (!same) begin
                    errors++; $display("FAIL pixel_stream: engine %0d got %0d pixels expected %0d (contents differ)", k, obs.size(), expq.size());
                end
                checks++;
                if (start_cyc !== (stuck[k] ? TO + 1 : script[k].size() + 1)) begin
                    errors++; $display("FAIL start_len: eng_start high %0d cycles expected %0d", start_cyc, stuck[k] ? TO + 1 : script[k].size() + 1);
                end
                obs.delete();
                start_cyc = 0;
                if (!hold) req[k] = 1'b0;
                done_cnt++;
            end
            if (!busy && done_cnt >= 1 && done_cnt < njobs) gaps++;
        end
        if (hold) req = '0;
        checks++;
        if (done_cnt !== njobs) begin
            errors++; $display("FAIL job_count: completed=%0d expected=%0d", done_cnt, njobs);
        end
        checks++;
        if (overlaps !== 0) begin
            errors++; $display("FAIL gnt_onehot: %0d cycles with multiple grants, expected 0", overlaps);
        end
        checks++;
        if (gaps !== njobs - 1) begin
            errors++; $display("FAIL idle_gap: busy low %0d cycles between jobs expected %0d", gaps, njobs - 1);
        end
        model_ptr = p;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0;
        for (int i = 0; i < N; i++) begin stuck[i] = 0; noise[i] = 0; pos[i] = 0; end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({gnt, job_done, job_abort, eng_start, vga_plot, busy} !== 12'd0) begin
            errors++; $display("FAIL reset_ctrl: got=%h expected=0", {gnt, job_done, job_abort, eng_start, vga_plot, busy});
        end
        checks++;
        if ({vga_x, vga_y, vga_colour, plot_count} !== 34'd0) begin
            errors++; $display("FAIL reset_data: got=%h expected=0", {vga_x, vga_y, vga_colour, plot_count});
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL idle_no_req: busy=%b expected=0", busy);
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N; i++) fill_random(i, $urandom_range(1, 5));
        run_jobs(3'b111, 4, 1'b1);
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        script[0].delete();
        script[0].push_back(mk(10, 20, 5, 1'b1));
        req = 3'b001;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 3'b001 || eng_start !== 3'b000 || busy !== 1'b1) begin
            errors++; $display("FAIL single_grant: gnt=%b start=%b busy=%b expected 001/000/1", gnt, eng_start, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (eng_start !== 3'b001 || vga_plot !== 1'b0) begin
            errors++; $display("FAIL single_start: start=%b plot=%b expected 001/0", eng_start, vga_plot);
        end
        @(posedge clk); #1;
        checks++;
        if (vga_plot !== 1'b1 || {vga_x, vga_y, vga_colour} !== {8'd10, 7'd20, 3'd5}) begin
            errors++; $display("FAIL single_pixel: plot=%b x=%0d y=%0d c=%0d expected 1,10,20,5", vga_plot, vga_x, vga_y, vga_colour);
        end
        @(posedge clk); #1;
        req = '0;
        checks++;
        if (eng_start !== 3'b000 || vga_plot !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_release: start=%b plot=%b busy=%b expected 000/0/1", eng_start, vga_plot, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (job_done !== 3'b001 || job_abort !== 1'b0 || plot_count !== 16'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done: done=%b abort=%b count=%0d busy=%b expected 001/0/1/0", job_done, job_abort, plot_count, busy);
        end
        model_ptr = 1;
    endtask

    task automatic test_clipping();
        script[0].delete();
        script[0].push_back(mk(160, 5, 7, 1'b1));
        script[0].push_back(mk(5, 120, 3, 1'b1));
        script[0].push_back(mk(159, 119, 6, 1'b1));
        run_jobs(3'b001, 1, 1'b0);
    endtask

    task automatic test_timeout();
        fill_random(0, 4);
        fill_random(1, 6);
        stuck[1] = 1;
        run_jobs(3'b011, 2, 1'b0);
        stuck[1] = 0;
    endtask

    task automatic test_noise();
        fill_random(0, 6);
        noise[2] = 1;
        run_jobs(3'b001, 1, 1'b0);
        noise[2] = 0;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        fill_random(1, 3);
        run_jobs(3'b010, 1, 1'b0);
        script[2].delete();
        for (int m = 0; m < 20; m++) script[2].push_back(mk(m, m, m % 8, 1'b1));
        req = 3'b100;
        cyc = 0;
        while (eng_start[2] !== 1'b1 && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (eng_start[2] !== 1'b1) begin
            errors++; $display("FAIL mid_start: eng_start=%b expected 100", eng_start);
        end
        repeat (2) begin @(posedge clk); #1; end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (eng_start !== 3'b000 || vga_plot !== 1'b0 || gnt !== 3'b000 || busy !== 1'b0) begin
            errors++; $display("FAIL async_reset: start=%b plot=%b gnt=%b busy=%b expected all 0", eng_start, vga_plot, gnt, busy);
        end
        req = '0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        fill_random(1, 4);
        run_jobs(3'b110, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [2:0] mask;
            mask = 3'($urandom_range(1, 7));
            for (int i = 0; i < N; i++) fill_random(i, $urandom_range(0, 8));
            run_jobs(mask, $countones(mask), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_clipping();
        test_timeout();
        test_noise();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
